// File: rtl/intra_mb_sched_pkg.sv
// Shared types for the intra 4x4 reconstruction scheduler and datapath.
// Holds the scheduler state encoding and the intra prediction mode codes.
package intra_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        RUN,
        HOLD,
        DONE
    } sched_state_t;

    typedef logic [2:0] intra_mode_t;

    localparam intra_mode_t VERT = 3'd0;
    localparam intra_mode_t HORZ = 3'd1;
    localparam intra_mode_t DC   = 3'd2;
    localparam intra_mode_t DDL  = 3'd3;
    localparam intra_mode_t VR   = 3'd4;
    localparam intra_mode_t HD   = 3'd5;
    localparam intra_mode_t VL   = 3'd6;
    localparam intra_mode_t DDR  = 3'd7;

    localparam int LAT_W = 4;

endpackage

// File: rtl/intra_mb_sched_mb_raster_cnt.sv
// Raster-order macroblock counter: linear index plus column/row,
// with the column wrapping at the end of each macroblock row.
module mb_raster_cnt #(
    parameter int MBS_X = 320,
    parameter int MBN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [MBN_W-1:0] mbnumber,
    output logic [MBN_W-1:0] mb_x,
    output logic [MBN_W-1:0] mb_y
);

    localparam logic [MBN_W-1:0] X_LAST = MBN_W'(MBS_X - 1);
    localparam logic [MBN_W-1:0] ONE    = MBN_W'(1);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            mbnumber <= '0;
            mb_x     <= '0;
            mb_y     <= '0;
        end else if (inc) begin
            mbnumber <= mbnumber + ONE;
            if (mb_x == X_LAST) begin
                mb_x <= '0;
                mb_y <= mb_y + ONE;
            end else begin
                mb_x <= mb_x + ONE;
            end
        end
    end

endmodule

// File: rtl/intra_mb_sched.sv
// Frame scheduler for the intra 4x4 reconstruction datapath.
// Optional stall counters are enabled with INTRA_SCHED_PERF_EN.
module intra_mb_sched
    import intra_pkg::*;
#(
    parameter int LENGTH    = 1280,
    parameter int WIDTH     = 720,
    parameter int MB_SIZE_L = 4,
    parameter int MB_SIZE_W = 4,
    parameter int MBN_W     = 16,
    parameter int RECON_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             res_valid,
    input  intra_mode_t      res_mode,
    output logic             res_ready,
    output logic             recon_en,
    output logic [MBN_W-1:0] recon_mbnumber,
    output intra_mode_t      recon_mode,
    output logic             mb_valid,
    input  logic             mb_ready,
    output logic [MBN_W-1:0] mb_x,
    output logic [MBN_W-1:0] mb_y,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
`ifdef INTRA_SCHED_PERF_EN
    ,
    output logic [31:0]      stall_in_cnt,
    output logic [31:0]      stall_out_cnt
`endif
);

    localparam int MBS_X  = LENGTH / MB_SIZE_L;
    localparam int MBS_Y  = WIDTH / MB_SIZE_W;
    localparam int NUM_MB = MBS_X * MBS_Y;

    localparam logic [MBN_W-1:0] MB_LAST  = MBN_W'(NUM_MB - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RECON_LAT - 1);

    sched_state_t     state;
    sched_state_t     state_next;
    logic [LAT_W-1:0] lat_cnt;
    logic             accept;
    logic             handoff;
    logic             last_mb;
    logic             lat_done;
    logic             cnt_clr;
    logic             cnt_inc;

    assign accept   = (state == FETCH) && res_valid;
    assign handoff  = (state == HOLD) && mb_ready;
    assign last_mb  = (recon_mbnumber == MB_LAST);
    assign lat_done = (lat_cnt == LAT_LAST);
    assign cnt_clr  = (state == IDLE) && start;
    assign cnt_inc  = handoff && !last_mb;

    mb_raster_cnt #(
        .MBS_X (MBS_X),
        .MBN_W (MBN_W)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (cnt_clr),
        .inc      (cnt_inc),
        .mbnumber (recon_mbnumber),
        .mb_x     (mb_x),
        .mb_y     (mb_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = FETCH;
            FETCH:   if (res_valid) state_next = RUN;
            RUN:     if (lat_done) state_next = HOLD;
            HOLD: begin
                if (mb_ready) begin
                    state_next = last_mb ? DONE : FETCH;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs depend on state only, except frame_start.
    always_comb begin
        res_ready   = 1'b0;
        recon_en    = 1'b0;
        mb_valid    = 1'b0;
        frame_done  = 1'b0;
        busy        = 1'b1;
        frame_start = accept && (recon_mbnumber == '0);
        unique case (state)
            IDLE:    busy       = 1'b0;
            FETCH:   res_ready  = 1'b1;
            RUN:     recon_en   = 1'b1;
            HOLD:    mb_valid   = 1'b1;
            DONE:    frame_done = 1'b1;
            default: busy       = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || state != RUN) begin
            lat_cnt <= '0;
        end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            recon_mode <= VERT;
        end else if (accept) begin
            recon_mode <= res_mode;
        end
    end

`ifdef INTRA_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            stall_in_cnt  <= '0;
            stall_out_cnt <= '0;
        end else begin
            if (state == FETCH && !res_valid && stall_in_cnt != '1) begin
                stall_in_cnt <= stall_in_cnt + 32'd1;
            end
            if (state == HOLD && !mb_ready && stall_out_cnt != '1) begin
                stall_out_cnt <= stall_out_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_intra_mb_sched.sv
// Self-checking bench for intra_mb_sched on a 16x8 frame (8 blocks).
// Build with INTRA_SCHED_PERF_EN to also cover the stall counters.
module tb_intra_mb_sched;

    localparam int LEN    = 16;
    localparam int WID    = 8;
    localparam int LAT    = 3;
    localparam int MBN_W  = 16;
    localparam int MBS_X  = LEN / 4;
    localparam int NUM_MB = MBS_X * (WID / 4);

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             res_valid;
    logic [2:0]       res_mode;
    logic             res_ready;
    logic             recon_en;
    logic [MBN_W-1:0] recon_mbnumber;
    logic [2:0]       recon_mode;
    logic             mb_valid;
    logic             mb_ready;
    logic [MBN_W-1:0] mb_x;
    logic [MBN_W-1:0] mb_y;
    logic             frame_start;
    logic             frame_done;
    logic             busy;
`ifdef INTRA_SCHED_PERF_EN
    logic [31:0]      stall_in_cnt;
    logic [31:0]      stall_out_cnt;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Reference model: 0 idle, 1 fetch, 2 run, 3 hold, 4 done
    int         m_st;
    int         m_blk;
    int         m_run;
    logic [2:0] m_mode;
    longint     m_sin;
    longint     m_sout;

    int fs_seen;
    int fd_seen;
    int hand_seen;
    int en_seen;

    always #5 clk = ~clk;

    intra_mb_sched #(
        .LENGTH    (LEN),
        .WIDTH     (WID),
        .MB_SIZE_L (4),
        .MB_SIZE_W (4),
        .MBN_W     (MBN_W),
        .RECON_LAT (LAT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .res_valid      (res_valid),
        .res_mode       (res_mode),
        .res_ready      (res_ready),
        .recon_en       (recon_en),
        .recon_mbnumber (recon_mbnumber),
        .recon_mode     (recon_mode),
        .mb_valid       (mb_valid),
        .mb_ready       (mb_ready),
        .mb_x           (mb_x),
        .mb_y           (mb_y),
        .frame_start    (frame_start),
        .frame_done     (frame_done),
        .busy           (busy)
`ifdef INTRA_SCHED_PERF_EN
        ,
        .stall_in_cnt   (stall_in_cnt),
        .stall_out_cnt  (stall_out_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_st = 0; m_blk = 0; m_mode = 3'd0; m_sin = 0; m_sout = 0;
        end else begin
            case (m_st)
                0: if (start) begin
                    m_st = 1; m_blk = 0; m_sin = 0; m_sout = 0;
                end
                1: if (res_valid) begin
                    m_mode = res_mode; m_st = 2; m_run = 0;
                end else begin
                    m_sin++;
                end
                2: begin
                    m_run++;
                    if (m_run == LAT) m_st = 3;
                end
                3: if (!mb_ready) m_sout++;
                   else if (m_blk == NUM_MB - 1) m_st = 4;
                   else begin m_blk++; m_st = 1; end
                default: m_st = 0;
            endcase
        end
    endtask

    // One clock: compare at negedge, advance model at posedge.
    task automatic cycle();
        logic [5:0] fl_o;
        logic [5:0] fl_e;
        @(negedge clk);
        fl_o = {res_ready, recon_en, mb_valid, frame_start, frame_done, busy};
        fl_e = {m_st == 1, m_st == 2, m_st == 3,
                m_st == 1 && res_valid && m_blk == 0, m_st == 4, m_st != 0};
        check("flags", fl_o, fl_e);
        check("mbnumber", recon_mbnumber, m_blk);
        check("mb_x", mb_x, m_blk % MBS_X);
        check("mb_y", mb_y, m_blk / MBS_X);
        check("recon_mode", recon_mode, m_mode);
`ifdef INTRA_SCHED_PERF_EN
        check("stall_in_cnt", stall_in_cnt, m_sin);
        check("stall_out_cnt", stall_out_cnt, m_sout);
`endif
        fs_seen   += int'(frame_start);
        fd_seen   += int'(frame_done);
        en_seen   += int'(recon_en);
        hand_seen += int'(mb_valid && mb_ready);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run_frame(input int rv_pct, input int mr_pct,
                             input bit seq, input int stall_blk,
                             input int in_stall, input int out_stall);
        int n = 0;
        int in_n = 0;
        int out_n = 0;
        fs_seen = 0; fd_seen = 0; hand_seen = 0; en_seen = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        while (m_st != 0 && n < 3000) begin
            res_valid = ($urandom_range(99) < rv_pct);
            mb_ready  = ($urandom_range(99) < mr_pct);
            res_mode  = seq ? 3'(m_blk) : 3'($urandom_range(7));
            start     = ($urandom_range(7) == 0);
            if (m_st == 1 && m_blk == stall_blk && in_n < in_stall) begin
                res_valid = 1'b0;
                in_n++;
            end
            if (m_st == 3 && m_blk == stall_blk && out_n < out_stall) begin
                mb_ready = 1'b0;
                out_n++;
            end
            cycle();
            n++;
        end
        start = 1'b0;
        check("frame_timeout", n >= 3000, 0);
        check("frame_start_pulses", fs_seen, 1);
        check("frame_done_pulses", fd_seen, 1);
        check("handoffs", hand_seen, NUM_MB);
        check("recon_en_cycles", en_seen, LAT * NUM_MB);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; res_valid = 1'b0;
        mb_ready = 1'b0; res_mode = 3'd0;
        m_st = 0; m_blk = 0; m_run = 0; m_mode = 3'd0; m_sin = 0; m_sout = 0;
        fs_seen = 0; fd_seen = 0; hand_seen = 0; en_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        cycle();
        reset = 1'b0;
        cycle();

        // Full throughput with sequenced modes 0..7
        run_frame(100, 100, 1'b1, -1, 0, 0);
        repeat (2) cycle();

        // Downstream stall of 5 cycles on block 2
        run_frame(100, 100, 1'b0, 2, 0, 5);

        // Upstream and downstream stalls on block 0
        run_frame(100, 100, 1'b0, 0, 4, 2);
`ifdef INTRA_SCHED_PERF_EN
        check("perf_in_final", stall_in_cnt, 4);
        check("perf_out_final", stall_out_cnt, 2);
`endif

        // Random handshakes, stray start pulses
        for (int f = 0; f < 3; f++) begin
            run_frame(60, 50, 1'b0, -1, 0, 0);
        end

        // Reset during RUN of block 5
        fd_seen = 0;
        start = 1'b1; cycle(); start = 1'b0;
        res_valid = 1'b1; mb_ready = 1'b1;
        n = 0;
        while (!(m_st == 2 && m_blk == 5) && n < 500) begin
            cycle();
            n++;
        end
        check("reach_blk5_timeout", n >= 500, 0);
        reset = 1'b1;
        cycle();
        reset = 1'b0; res_valid = 1'b0; mb_ready = 1'b0;
        repeat (3) cycle();
        check("no_done_after_reset", fd_seen, 0);
        check("idle_after_reset", busy, 1'b0);

        // Restart from mbnumber 0
        run_frame(80, 80, 1'b1, -1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/intra_mb_sched.md
Name: intra_mb_sched

Overview:
Frame-level scheduler for the 4x4 intra reconstruction datapath. It walks macroblock numbers in raster order across a LENGTH x WIDTH frame and accepts one residue block plus mode per macroblock from the upstream inverse-transform stage. It drives the datapath's enable, mbnumber and mode inputs, waits out the datapath latency, then presents a completion handshake to the downstream frame writer. It also flags start and end of frame.

Parameters:
LENGTH, 1280, frame width in pixels
WIDTH, 720, frame height in pixels
MB_SIZE_L, 4, macroblock width in pixels; must be a power of 2
MB_SIZE_W, 4, macroblock height in pixels; must be a power of 2
MBN_W, 16, width of the macroblock counter; must hold NUM_MB-1
RECON_LAT, 1, datapath cycles from the enable cycle to a valid mb output; range 1..15

Ports:
clk  in  1  single clock; all state changes on posedge
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse, begins a frame; ignored unless IDLE
res_valid  in  1  upstream residue block and mode are valid
res_mode  in  3  intra mode for the block
res_ready  out  1  scheduler accepts the block this cycle
recon_en  out  1  datapath enable
recon_mbnumber  out  MBN_W  current macroblock index
recon_mode  out  3  registered mode for the current block
mb_valid  out  1  reconstructed block is available on the datapath output
mb_ready  in  1  downstream accepts the block
mb_x  out  MBN_W  macroblock column index
mb_y  out  MBN_W  macroblock row index
frame_start  out  1  one-cycle pulse on the first accept of a frame
frame_done  out  1  one-cycle pulse after the last block is handed off
busy  out  1  high in every state except IDLE

Behaviour:
- Derived constants: MBS_X = LENGTH/MB_SIZE_L, MBS_Y = WIDTH/MB_SIZE_W, NUM_MB = MBS_X*MBS_Y.
- Reset: state IDLE. All counters are 0. res_ready, recon_en, mb_valid, frame_start, frame_done and busy are 0. recon_mode is 0.
- FSM states are IDLE, FETCH, RUN, HOLD and DONE.
- IDLE: on start, clear the counters and go to FETCH.
- FETCH: res_ready = 1.
  - On res_valid & res_ready, latch res_mode into recon_mode and go to RUN.
  - frame_start pulses on the same cycle when the accepted block has mbnumber 0.
- RUN: recon_en = 1 for exactly RECON_LAT cycles, counted with a 4-bit latency counter. Then go to HOLD.
- HOLD: recon_en = 0 and mb_valid = 1. mb_valid stays high until mb_ready.
  - On mb_valid & mb_ready, if recon_mbnumber == NUM_MB-1, go to DONE.
  - Otherwise increment recon_mbnumber and go to FETCH.
  - mb_x increments and wraps to 0 at MBS_X-1. On that wrap, mb_y increments.
- DONE: frame_done = 1 for one cycle, then go to IDLE. Counters hold their final values until the next start.
- recon_mbnumber, mb_x, mb_y and recon_mode stay stable from the accept until the handoff.
- No combinational path from res_valid to res_ready, or from mb_ready to mb_valid.
- Boundaries:
  - res_valid with res_ready low: ignored; upstream holds its data.
  - start while busy: ignored.
  - mb_ready held high before mb_valid: no effect.
  - res_valid high in the same cycle FETCH is entered: accepted that cycle.
  - reset mid-frame: returns to IDLE next cycle with the reset values above; no frame_done pulse.
  - NUM_MB == 1: sequence is FETCH, RUN, HOLD, DONE.

Optional Feature:
Macro INTRA_SCHED_PERF_EN.
- Defined: adds output ports stall_in_cnt [31:0] and stall_out_cnt [31:0].
  - stall_in_cnt counts FETCH cycles with res_valid low.
  - stall_out_cnt counts HOLD cycles with mb_ready low.
  - Both clear on reset and on an accepted start, and saturate at all ones.
- Undefined: neither port nor its logic exists. Every other behaviour is identical.

Decomposition:
- Package intra_pkg holds:
  - typedef enum logic [2:0] sched_state_t {IDLE, FETCH, RUN, HOLD, DONE};
  - typedef logic [2:0] intra_mode_t, shared with the reconstruction datapath;
  - the mode constants VERT=0 through DDR=7.
- One natural sub-module: mb_raster_cnt. It holds the mbnumber/mb_x/mb_y counter with its wrap logic and has inc/clr inputs.

Test Plan:
- LENGTH=16, WIDTH=8 (NUM_MB=8), RECON_LAT=1, res_valid and mb_ready tied high:
  - start produces 8 blocks, each taking FETCH, RUN, HOLD;
  - frame_start pulses once, on the first accept;
  - frame_done pulses once, 1 cycle after the 8th handoff;
  - mb_x/mb_y run (0,0)..(3,0),(0,1)..(3,1).
- Same frame, res_mode sequenced 0..7: recon_mode equals the accepted value for the whole of RUN and HOLD of each block.
- RECON_LAT=3: recon_en stays high exactly 3 cycles per block, and mb_valid rises on the 4th cycle after the accept.
- mb_ready low for 5 cycles on block 2: mb_valid stays high, recon_mbnumber stays 2, and no next res_ready appears until the handoff.
- reset asserted while in RUN of block 5: next cycle is IDLE with counters 0 and no frame_done pulse. A new start restarts at mbnumber 0.
- With INTRA_SCHED_PERF_EN defined, res_valid low for 4 FETCH cycles and mb_ready low for 2 HOLD cycles: stall_in_cnt = 4 and stall_out_cnt = 2.
